// File: rtl/edge_frame_sequencer.sv
// edge_frame_sequencer
//   Frame-level controller for the edge-detection pipeline. On an accepted
//   start it clears the downstream pipeline (pipe_rst), streams one
//   IMG_W x IMG_H frame out of a fixed-latency pixel memory in raster order,
//   counts NMS results and finishes with a one-cycle done pulse. A drain that
//   sees no result for DRAIN_TO cycles ends in ERR with error set.
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start, abort, pause frame control inputs
//   mem_rd_en/addr/data pixel memory read port (data valid RD_LAT cycles later)
//   pixel_out(_vld)     pixel stream to the first pixel_loader
//   pipe_rst            active-high clear for the downstream pipeline
//   result_valid        NMS output strobe, counted into res_count
//   pix_x, pix_y        coordinates of the last issued read
//   busy, done, error   status
module edge_frame_sequencer #(
  parameter int IMG_W     = 512,
  parameter int IMG_H     = 512,
  parameter int PIX_W     = 8,
  parameter int ADDR_W    = 18,
  parameter int RD_LAT    = 2,
  parameter int EXP_OUT   = 258064,
  parameter int FLUSH_CYC = 4,
  parameter int DRAIN_TO  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              pause,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [PIX_W-1:0]  mem_rd_data,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              pixel_out_vld,
  output logic              pipe_rst,
  input  logic              result_valid,
  output logic [15:0]       pix_x,
  output logic [15:0]       pix_y,
  output logic [ADDR_W-1:0] res_count,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam int TW = (DRAIN_TO > 1) ? $clog2(DRAIN_TO) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] EXP_CNT    = ADDR_W'(EXP_OUT);
  localparam logic [FW-1:0]     FLUSH_LAST = FW'(FLUSH_CYC - 1);
  localparam logic [TW-1:0]     TO_LAST    = TW'(DRAIN_TO - 1);
  localparam logic [15:0]       X_LAST     = 16'(IMG_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_FEED, S_DRAIN, S_DONE, S_ERR} state_t;
  state_t state, state_nxt;

  logic [FW-1:0]     flush_cnt;
  logic [TW-1:0]     idle_cnt;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       cur_x, cur_y;     // coordinates of the next read
  logic [RD_LAT:1]   vld_pipe;         // reads in flight, tail = data valid now
  logic              abort_q;
  logic              start_ok, last_rd, drained, timeout, res_hit;

  assign mem_rd_en   = (state == S_FEED) && !pause;
  assign mem_rd_addr = addr;
  assign busy        = (state == S_FLUSH) || (state == S_FEED) || (state == S_DRAIN);
  assign done        = (state == S_DONE);
  // abort_q stretches an abort into a one-cycle pipeline clear after the FSM
  // has already dropped back to IDLE.
  assign pipe_rst    = (state == S_FLUSH) || abort_q;

  assign start_ok = start && !abort &&
                    ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign last_rd  = mem_rd_en && (addr == LAST_ADDR);
  assign drained  = (vld_pipe == '0) && (res_count == EXP_CNT);
  assign timeout  = !result_valid && (idle_cnt == TO_LAST);
  assign res_hit  = result_valid && !abort && ((state == S_FEED) || (state == S_DRAIN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nxt = S_FLUSH;
        S_FLUSH: if (flush_cnt == FLUSH_LAST) state_nxt = S_FEED;
        S_FEED:  if (last_rd) state_nxt = S_DRAIN;
        S_DRAIN: begin
          if (drained)      state_nxt = S_DONE;
          else if (timeout) state_nxt = S_ERR;
        end
        S_DONE:  state_nxt = start ? S_FLUSH : S_IDLE;
        S_ERR:   if (start) state_nxt = S_FLUSH;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abort_q       <= 1'b0;
      vld_pipe      <= '0;
      pixel_out     <= '0;
      pixel_out_vld <= 1'b0;
      flush_cnt     <= '0;
      idle_cnt      <= '0;
      addr          <= '0;
      cur_x         <= '0;
      cur_y         <= '0;
      pix_x         <= '0;
      pix_y         <= '0;
      res_count     <= '0;
      error         <= 1'b0;
    end else begin
      abort_q <= abort;

      // Reads already issued always complete unless the frame is aborted.
      if (abort) begin
        vld_pipe <= '0;
      end else begin
        vld_pipe[1] <= mem_rd_en;
        for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
      pixel_out_vld <= vld_pipe[RD_LAT] && !abort;
      if (vld_pipe[RD_LAT]) pixel_out <= mem_rd_data;

      flush_cnt <= (state == S_FLUSH) ? flush_cnt + FW'(1) : '0;
      idle_cnt  <= (state == S_DRAIN && !result_valid) ? idle_cnt + TW'(1) : '0;

      if (start_ok) begin
        addr      <= '0;
        cur_x     <= '0;
        cur_y     <= '0;
        pix_x     <= '0;
        pix_y     <= '0;
        res_count <= '0;
        error     <= 1'b0;
      end else if (!abort) begin
        if (mem_rd_en) begin
          pix_x <= cur_x;
          pix_y <= cur_y;
          if (!last_rd) addr <= addr + ADDR_W'(1);
          if (cur_x == X_LAST) begin
            cur_x <= '0;
            cur_y <= cur_y + 16'd1;
          end else begin
            cur_x <= cur_x + 16'd1;
          end
        end
        // Saturate at EXP_OUT; an extra result is an overrun.
        if (res_hit) begin
          if (res_count == EXP_CNT) error <= 1'b1;
          else                      res_count <= res_count + ADDR_W'(1);
        end
        if (state == S_DRAIN && !drained && timeout) error <= 1'b1;
      end
    end
  end

endmodule
